pipe_hazard_tracker: RTL
========================

# pipe_hazard_tracker

Pipeline-side companion of the hazard unit. It holds the hazard-relevant fields of every in-flight instruction in shadow IF/ID, ID/EX, EX/MEM and MEM/WB registers, and drives the hazard unit's inputs from them. It applies the hazard unit's stall and flush outputs to advance, hold, bubble or squash those registers. It also tracks halt drain and counts retired instructions. It sits in the datapath beside the real pipeline latches, clocked identically.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- if_valid  in  1  fetch delivers a real instruction this cycle
- if_instr  in  32  fetched instruction word (word_t)
- ifid_stall, idex_stall, exmem_stall, memwb_stall  in  1 each  per-stage hold from hazard unit
- flushed  in  1  squash IF/ID and ID/EX (branch/jump taken)
- rs, rt  out  regbits_t  source registers of IF/ID instruction
- idex_opcode, idex_rd, idex_rt, idex_RegWrite  out  opcode_t/regbits_t/regbits_t/1  ID/EX fields
- exmem_opcode, exmem_rd, exmem_rt, exmem_RegWrite  out  same, EX/MEM fields
- memwb_rd, memwb_RegWrite  out  regbits_t/1  MEM/WB destination
- fetch_gate  out  1  halt has entered IF/ID; fetch must stop
- halt_done  out  1  halt has reached MEM/WB; sticky until reset
- retire_cnt  out  CNT_W  non-bubble instructions that have entered MEM/WB

## Operation
- Decode at IF/ID load:
  - opcode = instr[31:26], rs = [25:21], rt = [20:16].
  - Destination: rd = [15:11] for RTYPE, rt for I-type writers, 31 for JAL.
- RegWrite = 1 for:
  - RTYPE with funct ≠ JR;
  - JAL, ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, LL, SC.
- RegWrite = 0 otherwise.
- Bubble: all fields 0, RegWrite 0, valid 0. Bubble is not counted.
- Per stage k, each cycle, in priority order:
  1. Flush: flushed = 1 on IF/ID or ID/EX → bubble. Flush beats stall.
  2. Hold: stall_k = 1 → hold.
  3. Bubble insert: upstream stage stalled, stall_k = 0 → bubble.
  4. Otherwise load upstream contents.
- IF/ID loads decode of if_instr when if_valid = 1 and fetch_gate = 0; otherwise it loads a bubble.
- fetch_gate:
  - Sets when a HALT opcode (6'b111111) is loaded into IF/ID and not flushed.
  - Clears if that halt is squashed by flushed before reaching EX/MEM.
- halt_done sets when a valid HALT enters MEM/WB. Once set, all stages freeze.
- retire_cnt increments by 1 when a valid non-bubble instruction enters MEM/WB. It wraps modulo 2^CNT_W and freezes after halt_done.

## Timing
- All outputs are registered; hazard-unit inputs reflect stage contents in the same cycle the stage is occupied.
- Reset: every output is 0, every stage holds a bubble, retire_cnt = 0.
- Stall/flush sampled at the rising edge of CLK; effect visible the next cycle.
- Latency: instruction accepted at edge n appears as:
  - rs/rt at n;
  - idex_* at n+1;
  - exmem_* at n+2;
  - memwb_* at n+3 (no stalls).
- Simultaneous cases:
  - flushed together with ifid_stall and idex_stall: both stages squash.
  - flushed together with exmem_stall: EX/MEM holds, ID/EX bubbles.
- Reset mid-operation: asynchronous clear of all state, including sticky halt_done.

## Structure
- pipe_types_pkg gains:
  - a stage_info_t struct: valid, opcode, rs, rt, rd, RegWrite;
  - BUBBLE constant;
  - function dest_of(word_t) returning destination and RegWrite.
- Opcode/funct enums come from cpu_types_pkg.
- One sub-module, pipe_stage_reg: a single stage_info_t register with hold/bubble/load control, instantiated four times.

## Test plan
- Reset: nRST low mid-stream → all outputs 0, halt_done 0, retire_cnt 0.
- Straight-line flow: ADDU r3,r1,r2 at cycle 0 → idex_rd = 3, idex_RegWrite = 1 at cycle 1; memwb_rd = 3 at cycle 3; retire_cnt = 1.
- Load-use stall: ifid_stall = idex_stall = 1 for one cycle behind LW r5 → EX/MEM gets bubble (exmem_RegWrite = 0) and the LW holds in ID/EX one extra cycle.
- Flush: BEQ taken, flushed = 1 with ORI r4 in IF/ID and SW in ID/EX → both become bubbles; retire_cnt excludes them.
- Flush dominance: flushed = 1 with ifid_stall = 1 → IF/ID still bubbles; with exmem_stall = 1, EX/MEM holds.
- Halt: HALT fetched → fetch_gate = 1 next cycle, halt_done = 1 three cycles later; further if_valid is ignored; a squashed HALT clears fetch_gate.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Basic CPU-wide types: machine word, register index, and the opcode and
// funct encodings of the MIPS-style instruction set (plus the HALT opcode).
// No ports; imported by the pipeline packages and modules.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        JAL   = 6'b000011,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        ADDI  = 6'b001000,
        ADDIU = 6'b001001,
        SLTI  = 6'b001010,
        SLTIU = 6'b001011,
        ANDI  = 6'b001100,
        ORI   = 6'b001101,
        XORI  = 6'b001110,
        LUI   = 6'b001111,
        LW    = 6'b100011,
        LBU   = 6'b100100,
        LHU   = 6'b100101,
        SB    = 6'b101000,
        SH    = 6'b101001,
        SW    = 6'b101011,
        LL    = 6'b110000,
        SC    = 6'b111000,
        HALT  = 6'b111111
    } opcode_t;

    typedef enum logic [5:0] {
        SLL  = 6'b000000,
        SRL  = 6'b000010,
        JR   = 6'b001000,
        ADD  = 6'b100000,
        ADDU = 6'b100001,
        SUB  = 6'b100010,
        SUBU = 6'b100011,
        AND  = 6'b100100,
        OR   = 6'b100101,
        XOR  = 6'b100110,
        NOR  = 6'b100111,
        SLT  = 6'b101010,
        SLTU = 6'b101011
    } funct_t;

endpackage

// File: rtl/pipe_types_pkg.sv
// pipe_types_pkg
// Pipeline-side types for the hazard tracker: the per-stage shadow record,
// the bubble value, and the decode helpers that turn a fetched word into
// the hazard-relevant fields. No ports.
package pipe_types_pkg;

    import cpu_types_pkg::*;

    typedef struct packed {
        logic     valid;
        opcode_t  opcode;
        regbits_t rs;
        regbits_t rt;
        regbits_t rd;
        logic     RegWrite;
    } stage_info_t;

    typedef struct packed {
        regbits_t rd;
        logic     RegWrite;
    } dest_t;

    localparam stage_info_t BUBBLE = '{
        valid:    1'b0,
        opcode:   RTYPE,
        rs:       '0,
        rt:       '0,
        rd:       '0,
        RegWrite: 1'b0
    };

    // Non-writing instructions report rd = 0 so they never alias a real
    // destination in the forwarding/hazard comparisons.
    function automatic dest_t dest_of(input word_t instr);
        dest_t d;
        d.rd       = '0;
        d.RegWrite = 1'b0;
        case (opcode_t'(instr[31:26]))
            RTYPE: begin
                d.rd       = instr[15:11];
                d.RegWrite = (funct_t'(instr[5:0]) != JR);
            end
            JAL: begin
                d.rd       = 5'd31;
                d.RegWrite = 1'b1;
            end
            ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, LL, SC: begin
                d.rd       = instr[20:16];
                d.RegWrite = 1'b1;
            end
            default: begin
                d.rd       = '0;
                d.RegWrite = 1'b0;
            end
        endcase
        return d;
    endfunction

    function automatic stage_info_t decode(input word_t instr);
        stage_info_t s;
        dest_t       d;
        d          = dest_of(instr);
        s.valid    = 1'b1;
        s.opcode   = opcode_t'(instr[31:26]);
        s.rs       = instr[25:21];
        s.rt       = instr[20:16];
        s.rd       = d.rd;
        s.RegWrite = d.RegWrite;
        return s;
    endfunction

    function automatic logic is_halt(input stage_info_t s);
        return s.valid && (s.opcode == HALT);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// One shadow pipeline register holding a stage_info_t.
// Ports:
//   CLK, nRST - clock and asynchronous active-low reset (resets to a bubble)
//   hold      - keep the current contents
//   clear     - load a bubble; takes priority over hold
//   d         - upstream contents loaded when neither hold nor clear
//   q         - current stage contents
module pipe_stage_reg
    import pipe_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        hold,
    input  logic        clear,
    input  stage_info_t d,
    output stage_info_t q
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= BUBBLE;
        end else if (clear) begin
            q <= BUBBLE;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_hazard_tracker.sv
// pipe_hazard_tracker
// Shadows the hazard-relevant fields of every in-flight instruction in
// IF/ID, ID/EX, EX/MEM and MEM/WB, applies the hazard unit's stall/flush
// decisions to them, and tracks halt drain and retired instructions.
// Ports:
//   CLK, nRST                         - clock, async active-low reset
//   if_valid, if_instr                - fetched instruction
//   ifid/idex/exmem/memwb_stall       - per-stage hold from the hazard unit
//   flushed                           - squash what enters IF/ID and ID/EX
//   rs, rt                            - IF/ID source registers
//   idex_*, exmem_*                   - opcode/rd/rt/RegWrite of those stages
//   memwb_rd, memwb_RegWrite          - MEM/WB destination
//   fetch_gate                        - a halt is in flight, stop fetching
//   halt_done                         - halt reached MEM/WB (sticky)
//   retire_cnt                        - count of real instructions into MEM/WB
module pipe_hazard_tracker
    import cpu_types_pkg::*;
    import pipe_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             if_valid,
    input  word_t            if_instr,
    input  logic             ifid_stall,
    input  logic             idex_stall,
    input  logic             exmem_stall,
    input  logic             memwb_stall,
    input  logic             flushed,
    output regbits_t         rs,
    output regbits_t         rt,
    output opcode_t          idex_opcode,
    output regbits_t         idex_rd,
    output regbits_t         idex_rt,
    output logic             idex_RegWrite,
    output opcode_t          exmem_opcode,
    output regbits_t         exmem_rd,
    output regbits_t         exmem_rt,
    output logic             exmem_RegWrite,
    output regbits_t         memwb_rd,
    output logic             memwb_RegWrite,
    output logic             fetch_gate,
    output logic             halt_done,
    output logic [CNT_W-1:0] retire_cnt
);

    stage_info_t fetch_info;
    stage_info_t ifid_q, idex_q, exmem_q, memwb_q;

    logic ifid_hold,  ifid_clear;
    logic idex_hold,  idex_clear;
    logic exmem_hold, exmem_clear;
    logic memwb_hold, memwb_clear;

    logic ifid_takes_halt;
    logic halt_squashed;
    logic memwb_load;
    logic retire_evt;
    logic halt_arrive;

    // While a halt is outstanding, fetch feeds bubbles instead of real work.
    assign fetch_info = (if_valid && !fetch_gate) ? decode(if_instr) : BUBBLE;

    // Once halt_done is set every stage freezes, overriding flush and stall.
    // Otherwise flush beats hold, hold beats bubble insertion behind a stall.
    assign ifid_hold   = halt_done | ifid_stall;
    assign ifid_clear  = ~halt_done & flushed;
    assign idex_hold   = halt_done | idex_stall;
    assign idex_clear  = ~halt_done & (flushed | (ifid_stall & ~idex_stall));
    assign exmem_hold  = halt_done | exmem_stall;
    assign exmem_clear = ~halt_done & idex_stall & ~exmem_stall;
    assign memwb_hold  = halt_done | memwb_stall;
    assign memwb_clear = ~halt_done & exmem_stall & ~memwb_stall;

    pipe_stage_reg u_ifid (
        .CLK   (CLK),
        .nRST  (nRST),
        .hold  (ifid_hold),
        .clear (ifid_clear),
        .d     (fetch_info),
        .q     (ifid_q)
    );

    pipe_stage_reg u_idex (
        .CLK   (CLK),
        .nRST  (nRST),
        .hold  (idex_hold),
        .clear (idex_clear),
        .d     (ifid_q),
        .q     (idex_q)
    );

    pipe_stage_reg u_exmem (
        .CLK   (CLK),
        .nRST  (nRST),
        .hold  (exmem_hold),
        .clear (exmem_clear),
        .d     (idex_q),
        .q     (exmem_q)
    );

    pipe_stage_reg u_memwb (
        .CLK   (CLK),
        .nRST  (nRST),
        .hold  (memwb_hold),
        .clear (memwb_clear),
        .d     (exmem_q),
        .q     (memwb_q)
    );

    // A flush replaces ID/EX with a bubble, so only a halt sitting in IF/ID
    // is lost to it; a halt already in ID/EX moves on into EX/MEM.
    assign ifid_takes_halt = ~ifid_hold & ~ifid_clear & is_halt(fetch_info);
    assign halt_squashed   = ~halt_done & flushed & is_halt(ifid_q);

    assign memwb_load  = ~memwb_hold & ~memwb_clear;
    assign retire_evt  = memwb_load & exmem_q.valid;
    assign halt_arrive = retire_evt & (exmem_q.opcode == HALT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_gate <= 1'b0;
        end else if (halt_squashed) begin
            fetch_gate <= 1'b0;
        end else if (ifid_takes_halt) begin
            fetch_gate <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt_done  <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (halt_arrive) begin
                halt_done <= 1'b1;
            end
            if (retire_evt) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    assign rs             = ifid_q.rs;
    assign rt             = ifid_q.rt;
    assign idex_opcode    = idex_q.opcode;
    assign idex_rd        = idex_q.rd;
    assign idex_rt        = idex_q.rt;
    assign idex_RegWrite  = idex_q.RegWrite;
    assign exmem_opcode   = exmem_q.opcode;
    assign exmem_rd       = exmem_q.rd;
    assign exmem_rt       = exmem_q.rt;
    assign exmem_RegWrite = exmem_q.RegWrite;
    assign memwb_rd       = memwb_q.rd;
    assign memwb_RegWrite = memwb_q.RegWrite;

    // MEM/WB carries the full record like every other stage, but only its
    // destination fields have a consumer.
    logic memwb_unused;
    assign memwb_unused = ^{memwb_q.valid, memwb_q.opcode, memwb_q.rs, memwb_q.rt};

endmodule
